// File: rtl/lmc1992_if.sv
// CPU-side Microwire register bus for the LMC1992 block (data 0xFF8922, mask 0xFF8924).
interface lmc1992_if;
  logic [15:0] din;
  logic        addr;
  logic        sel;
  logic        uds;
  logic        lds;
  logic        rw;
  logic [15:0] dout;
  logic        mw_busy;

  modport master (output din, addr, sel, uds, lds, rw, input  dout, mw_busy);
  modport slave  (input  din, addr, sel, uds, lds, rw, output dout, mw_busy);
endinterface

// File: rtl/lmc1992.sv
// STE LMC1992 volume/tone controller with Microwire host interface and 3-stage gain pipeline.
// Optional: define LMC1992_SAT_EN to saturate the output to 15-bit signed instead of wrapping.
module lmc1992 #(
  parameter int MW_DIV = 2
) (
  input  logic        clk_32,
  input  logic        reset,
  input  logic        clk_2_en,
  lmc1992_if.slave    bus,
  input  logic [9:0]  ym_l,
  input  logic [9:0]  ym_r,
  input  logic [7:0]  ste_l,
  input  logic [7:0]  ste_r,
  output logic [14:0] audio_l,
  output logic [14:0] audio_r
);

  localparam logic [7:0] DIV_LAST = 8'(MW_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DECODE} mw_state_t;

  mw_state_t   state, state_nxt;
  logic [15:0] data_sr, mask_sr;
  logic [10:0] lmc_sr;
  logic [4:0]  bit_cnt;
  logic [7:0]  div_cnt;
  logic [3:0]  tick_cnt;
  logic        busy, do_decode, tick, wr_data, wr_mask, decode_ok;

  logic [1:0]  mix;
  logic [3:0]  bass, treble;
  logic [5:0]  master;
  logic [4:0]  left, right;

  assign wr_data = bus.sel & ~bus.rw & bus.addr;
  assign wr_mask = bus.sel & ~bus.rw & ~bus.addr & ~busy;
  assign tick    = busy & clk_2_en & (div_cnt == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_32) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: default assignment first, so no path through the block can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (wr_data) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (wr_data) state_nxt = ST_SHIFT;
                 else if (tick && tick_cnt == 4'd15) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = wr_data ? ST_SHIFT : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ST_SHIFT);
    do_decode = (state == ST_DECODE);
  end

  assign bus.mw_busy = busy;

  // A data write restarts the transfer; ticks rotate both registers back to their written values.
  always_ff @(posedge clk_32) begin
    if (reset) begin
      data_sr  <= '0;
      mask_sr  <= '0;
      lmc_sr   <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      if (wr_data) begin
        if (bus.uds) data_sr[15:8] <= bus.din[15:8];
        if (bus.lds) data_sr[7:0]  <= bus.din[7:0];
        lmc_sr   <= '0;
        bit_cnt  <= '0;
        div_cnt  <= '0;
        tick_cnt <= '0;
      end else if (tick) begin
        if (mask_sr[15]) begin
          lmc_sr <= {lmc_sr[9:0], data_sr[15]};
          if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
        end
        data_sr  <= {data_sr[14:0], data_sr[15]};
        mask_sr  <= {mask_sr[14:0], mask_sr[15]};
        div_cnt  <= '0;
        tick_cnt <= tick_cnt + 4'd1;
      end else if (busy && clk_2_en) begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (wr_mask) begin
        if (bus.uds) mask_sr[15:8] <= bus.din[15:8];
        if (bus.lds) mask_sr[7:0]  <= bus.din[7:0];
      end
    end
  end

  always_ff @(posedge clk_32) begin
    if (reset)                 bus.dout <= '0;
    else if (bus.sel && bus.rw) bus.dout <= bus.addr ? data_sr : mask_sr;
    else                       bus.dout <= '0;
  end

  assign decode_ok = do_decode && (bit_cnt == 5'd11) && (lmc_sr[10:9] == 2'b10);

  always_ff @(posedge clk_32) begin
    if (reset) begin
      mix    <= 2'b01;
      master <= 6'd40;
      left   <= 5'd20;
      right  <= 5'd20;
      bass   <= 4'd6;
      treble <= 4'd6;
    end else if (decode_ok) begin
      case (lmc_sr[8:6])
        3'b000:  mix    <= lmc_sr[1:0];
        3'b001:  bass   <= lmc_sr[3:0];
        3'b010:  treble <= lmc_sr[3:0];
        3'b011:  master <= (lmc_sr[5:0] > 6'd40) ? 6'd40 : lmc_sr[5:0];
        3'b100:  right  <= (lmc_sr[4:0] > 5'd20) ? 5'd20 : lmc_sr[4:0];
        3'b101:  left   <= (lmc_sr[4:0] > 5'd20) ? 5'd20 : lmc_sr[4:0];
        default: ;
      endcase
    end
  end

  // Tone settings are held for software readback compatibility only; no filtering is applied.
  logic unused_tone;
  assign unused_tone = ^{bass, treble};

  function automatic logic signed [15:0] mix_src(logic [9:0] ym, logic [7:0] ste, logic [1:0] sel_mix);
    logic signed [15:0] ys, ss;
    ys = {{2{~ym[9]}}, ~ym[9], ym[8:0], 4'b0};
    ss = {{2{~ste[7]}}, ~ste[7], ste[6:0], 6'b0};
    case (sel_mix)
      2'b10:   return ss;
      2'b00:   return (ys >>> 2) + ss;
      default: return ys + ss;
    endcase
  endfunction

  function automatic logic [8:0] coef(logic [1:0] idx);
    case (idx)
      2'd0:    return 9'd256;
      2'd1:    return 9'd203;
      default: return 9'd161;
    endcase
  endfunction

  logic [9:0]         ym_in   [2];
  logic [7:0]         ste_in  [2];
  logic [4:0]         side    [2];
  logic [6:0]         atten   [2];
  logic signed [15:0] m_nxt   [2];
  logic signed [25:0] s3_full [2];
  logic [14:0]        o_nxt   [2];

  logic signed [15:0] s1_m    [2];
  logic [1:0]         s1_idx  [2];
  logic [3:0]         s1_sh   [2];
  logic               s1_mute [2];
  logic signed [25:0] s2_p    [2];
  logic [3:0]         s2_sh   [2];
  logic               s2_mute [2];
  logic [14:0]        s3_o    [2];

  always_comb begin
    ym_in  = '{ym_l, ym_r};
    ste_in = '{ste_l, ste_r};
    side   = '{left, right};
    for (int c = 0; c < 2; c++) begin
      m_nxt[c]   = mix_src(ym_in[c], ste_in[c], mix);
      atten[c]   = 7'd60 - {1'b0, master} - {2'b0, side[c]};
      s3_full[c] = s2_mute[c] ? 26'sd0 : ((s2_p[c] >>> 8) >>> s2_sh[c]);
`ifdef LMC1992_SAT_EN
      if (s3_full[c] > 26'sd16383)       o_nxt[c] = 15'h3FFF;
      else if (s3_full[c] < -26'sd16384) o_nxt[c] = 15'h4000;
      else                               o_nxt[c] = s3_full[c][14:0];
`else
      o_nxt[c] = s3_full[c][14:0];
`endif
    end
  end

`ifndef LMC1992_SAT_EN
  logic unused_s3_hi;
  assign unused_s3_hi = ^{s3_full[0][25:15], s3_full[1][25:15]};
`endif

  // Each stage carries the gain it was issued with, so a decode never mixes old and new settings.
  always_ff @(posedge clk_32) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        s1_m[c]    <= '0;
        s1_idx[c]  <= '0;
        s1_sh[c]   <= '0;
        s1_mute[c] <= 1'b0;
        s2_p[c]    <= '0;
        s2_sh[c]   <= '0;
        s2_mute[c] <= 1'b0;
        s3_o[c]    <= '0;
      end else begin
        s1_m[c]    <= m_nxt[c];
        s1_idx[c]  <= 2'(atten[c] % 7'd3);
        s1_sh[c]   <= 4'(atten[c] / 7'd3);
        s1_mute[c] <= (atten[c] >= 7'd40);
        s2_p[c]    <= s1_m[c] * $signed({1'b0, coef(s1_idx[c])});
        s2_sh[c]   <= s1_sh[c];
        s2_mute[c] <= s1_mute[c];
        s3_o[c]    <= o_nxt[c];
      end
    end
  end

  assign audio_l = s3_o[0];
  assign audio_r = s3_o[1];

endmodule

// File: tb/tb_lmc1992.sv
// Randomized self-checking bench for lmc1992 against an arithmetic reference model.
module tb_lmc1992;
  logic        clk_32 = 1'b0;
  logic        reset;
  logic        clk_2_en = 1'b0;
  logic [9:0]  ym_l, ym_r;
  logic [7:0]  ste_l, ste_r;
  logic [14:0] audio_l, audio_r;

  lmc1992_if bus();

  lmc1992 #(.MW_DIV(2)) dut (
    .clk_32   (clk_32),
    .reset    (reset),
    .clk_2_en (clk_2_en),
    .bus      (bus),
    .ym_l     (ym_l),
    .ym_r     (ym_r),
    .ste_l    (ste_l),
    .ste_r    (ste_r),
    .audio_l  (audio_l),
    .audio_r  (audio_r)
  );

  always #5 clk_32 = ~clk_32;

  int en_cnt = 0;
  always @(negedge clk_32) begin
    en_cnt   = (en_cnt + 1) % 16;
    clk_2_en = (en_cnt == 0);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else             n_pass++;
  endtask

  // Reference model state: the programmable controls as plain integers.
  int m_mix, m_master, m_left, m_right;

  function automatic void model_reset();
    m_mix = 1; m_master = 40; m_left = 20; m_right = 20;
  endfunction

  // Collect the data bits selected by the mask, MSB first; accept only an 11-bit word with address 10.
  function automatic void model_decode(input logic [15:0] mask, input logic [15:0] data);
    int n = 0;
    int bits = 0;
    int cmd, val;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) begin
        bits = ((bits << 1) | int'(data[i])) & 'h7FF;
        n++;
      end
    end
    if (n != 11 || ((bits >> 9) & 3) != 2) return;
    cmd = (bits >> 6) & 7;
    val = bits & 63;
    case (cmd)
      0: m_mix    = val & 3;
      3: m_master = (val > 40) ? 40 : val;
      4: m_right  = ((val & 31) > 20) ? 20 : (val & 31);
      5: m_left   = ((val & 31) > 20) ? 20 : (val & 31);
      default: ;
    endcase
  endfunction

  function automatic int model_audio(input int ym, input int ste, input int side_vol);
    int ys = (ym - 512) * 16;
    int ss = (ste - 128) * 64;
    int m, a, cf, o;
    if (m_mix == 2)      m = ss;
    else if (m_mix == 0) m = (ys >>> 2) + ss;
    else                 m = ys + ss;
    a = (40 - m_master) + (20 - side_vol);
    if (a >= 40) return 0;
    cf = (a % 3 == 0) ? 256 : (a % 3 == 1) ? 203 : 161;
    o  = ((m * cf) >>> 8) >>> (a / 3);
    return o & 'h7FFF;
  endfunction

  function automatic int is_rot(input logic [15:0] v, input logic [15:0] w);
    logic [15:0] r;
    for (int k = 0; k < 16; k++) begin
      r = (w << k) | (w >> (16 - k));
      if (v == r) return 1;
    end
    return 0;
  endfunction

  task automatic cpu_write(input logic a, input logic [15:0] d);
    @(negedge clk_32);
    bus.sel = 1'b1; bus.rw = 1'b0; bus.addr = a; bus.din = d;
    @(negedge clk_32);
    bus.sel = 1'b0; bus.rw = 1'b1;
  endtask

  task automatic cpu_read(input logic a, output logic [15:0] d);
    @(negedge clk_32);
    bus.sel = 1'b1; bus.rw = 1'b1; bus.addr = a;
    @(negedge clk_32);
    d = bus.dout;
    bus.sel = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.mw_busy && n < 2000) begin
      @(negedge clk_32);
      n++;
    end
    if (n >= 2000) check("busy_timeout", int'(bus.mw_busy), 0);
  endtask

  task automatic mw_send(input logic [15:0] mask, input logic [15:0] data);
    int n;
    logic [15:0] rd;
    cpu_write(1'b0, mask);
    cpu_write(1'b1, data);
    wait_idle(n);
    check("xfer_len", int'(n >= 497 && n <= 512), 1);
    model_decode(mask, data);
    repeat (2) @(negedge clk_32);
    cpu_read(1'b1, rd);
    check("xfer_data_back", int'(rd), int'(data));
  endtask

  task automatic audio_trial(input string tag, input int yl, input int yr, input int sl, input int sr);
    @(negedge clk_32);
    ym_l = 10'(yl); ym_r = 10'(yr); ste_l = 8'(sl); ste_r = 8'(sr);
    repeat (3) @(posedge clk_32);
    @(negedge clk_32);
    check({tag, "_l"}, int'(audio_l), model_audio(yl, sl, m_left));
    check({tag, "_r"}, int'(audio_r), model_audio(yr, sr, m_right));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    int n;
    reset = 1'b1;
    bus.sel = 1'b0; bus.rw = 1'b1; bus.uds = 1'b1; bus.lds = 1'b1; bus.addr = 1'b0; bus.din = '0;
    ym_l = 10'h200; ym_r = 10'h200; ste_l = 8'hFF; ste_r = 8'hFF;
    model_reset();
    repeat (3) @(posedge clk_32);
    @(negedge clk_32);
    reset = 1'b0;

    // Reset defaults
    check("rst_busy", int'(bus.mw_busy), 0);
    check("rst_dout", int'(bus.dout), 0);
    cpu_read(1'b1, rd); check("rst_data_sr", int'(rd), 0);
    cpu_read(1'b0, rd); check("rst_mask_sr", int'(rd), 0);
    audio_trial("rst_audio", 'h200, 'h200, 'hFF, 'hFF);

    // Microwire timing, master 40, registers return to written values
    mw_send(16'h07FF, 16'h04E8);
    cpu_read(1'b0, rd); check("mask_back", int'(rd), 'h07FF);
    @(negedge clk_32); check("dout_desel", int'(bus.dout), 0);
    audio_trial("master40", 'h200, 'h200, 'hFF, 'hFF);

    // Mid-transfer read shows a rotation; left volume 10
    cpu_write(1'b0, 16'h07FF);
    cpu_write(1'b1, 16'h054A);
    repeat (150) @(negedge clk_32);
    check("mid_busy", int'(bus.mw_busy), 1);
    cpu_read(1'b1, rd); check("mid_rot", is_rot(rd, 16'h054A), 1);
    wait_idle(n);
    model_decode(16'h07FF, 16'h054A);
    repeat (2) @(negedge clk_32);
    audio_trial("left10", 'h200, 'h200, 'hFF, 'hFF);

    // Mix modes with left back at 20
    mw_send(16'h07FF, 16'h0554);
    mw_send(16'h07FF, 16'h0402);
    audio_trial("mix_dma", 'h3FF, 'h3FF, 'h80, 'h80);
    mw_send(16'h07FF, 16'h0400);
    audio_trial("mix_00", 'h3FF, 'h3FF, 'h80, 'h80);

    // Bad transfers: 12 bits, wrong address
    mw_send(16'h0FFF, 16'h0540);
    mw_send(16'h07FF, 16'h0340);
    audio_trial("bad_xfer", 'h3FF, 'h100, 'h80, 'hC0);

    // Abort: a mute command cut short by a new data write is never decoded
    cpu_write(1'b0, 16'h07FF);
    cpu_write(1'b1, 16'h04C0);
    repeat (200) @(negedge clk_32);
    cpu_write(1'b1, 16'h0000);
    wait_idle(n);
    check("restart_len", int'(n >= 497 && n <= 512), 1);
    repeat (2) @(negedge clk_32);
    audio_trial("abort", 'h300, 'h200, 'h90, 'hFF);

    // Mute, then full scale at 0 dB
    mw_send(16'h07FF, 16'h04C0);
    audio_trial("mute", 'h3FF, 'h3FF, 'hFF, 'hFF);
    mw_send(16'h07FF, 16'h0401);
    mw_send(16'h07FF, 16'h04E8);
    mw_send(16'h07FF, 16'h0554);
    mw_send(16'h07FF, 16'h0514);
    audio_trial("full_scale", 'h3FF, 'h3FF, 'hFF, 'hFF);
    audio_trial("neg_scale", 'h000, 'h000, 'h00, 'h00);

    // Reset mid-shift drops the transfer
    cpu_write(1'b0, 16'h07FF);
    cpu_write(1'b1, 16'h04C0);
    repeat (100) @(negedge clk_32);
    reset = 1'b1;
    @(negedge clk_32);
    reset = 1'b0;
    model_reset();
    check("rst_mid_busy", int'(bus.mw_busy), 0);
    cpu_read(1'b1, rd); check("rst_mid_data", int'(rd), 0);
    audio_trial("rst_mid_audio", 'h1F0, 'h210, 'hA0, 'h40);

    // Randomized commands and samples
    for (int t = 0; t < 10; t++) begin
      logic [15:0] mask, data;
      logic [1:0]  adr;
      logic [2:0]  cmd;
      logic [5:0]  val;
      int pick;
      cmd  = 3'($urandom_range(0, 7));
      val  = 6'($urandom_range(0, 63));
      adr  = ($urandom_range(0, 4) == 0) ? 2'b01 : 2'b10;
      pick = $urandom_range(0, 5);
      if (pick == 0) begin
        mask = 16'hFFE0;
        data = {adr, cmd, val, 5'($urandom)};
      end else begin
        mask = (pick == 1) ? 16'h0FFF : (pick == 2) ? 16'h03FF : 16'h07FF;
        data = {5'($urandom), adr, cmd, val};
      end
      mw_send(mask, data);
      for (int s = 0; s < 3; s++)
        audio_trial("rand", $urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 255), $urandom_range(0, 255));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
